// File: rtl/acondicionador_entradas_if.sv
// Signal bundle between the traffic-light environment and the input conditioner.
//   master : drives the sample strobe, raw sensors/buttons and the controller's red lights;
//            observes the conditioned sensor levels and held crossing requests.
//   slave  : the conditioner itself (acondicionador_entradas).
// Signals:
//   tick                 sample-enable strobe, one clk wide
//   raw_sensor_a/b       asynchronous vehicle sensors
//   raw_paso_a/b         asynchronous pedestrian buttons
//   rojo_a/b             controller red lights (service feedback)
//   sensor_a/b           debounced sensor levels
//   paso_a/b             pending crossing requests
interface acondicionador_entradas_if;
    logic tick;
    logic raw_sensor_a;
    logic raw_sensor_b;
    logic raw_paso_a;
    logic raw_paso_b;
    logic rojo_a;
    logic rojo_b;
    logic sensor_a;
    logic sensor_b;
    logic paso_a;
    logic paso_b;

    modport master (
        output tick, raw_sensor_a, raw_sensor_b, raw_paso_a, raw_paso_b, rojo_a, rojo_b,
        input  sensor_a, sensor_b, paso_a, paso_b
    );

    modport slave (
        input  tick, raw_sensor_a, raw_sensor_b, raw_paso_a, raw_paso_b, rojo_a, rojo_b,
        output sensor_a, sensor_b, paso_a, paso_b
    );
endinterface

// File: rtl/acondicionador_entradas.sv
// Input stage of the two-way traffic-light controller.
// Synchronises and debounces the vehicle sensors and pedestrian buttons of streets A and B,
// and turns button presses into crossing requests held until the controller has served
// them (red phase started). A press during an active red phase is queued for the next one.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-low
//   bus  : acondicionador_entradas_if.slave (strobe, raw inputs, red feedback, outputs)
module acondicionador_entradas #(
    parameter int unsigned DEB_TICKS = 8,
    parameter int unsigned CW        = 4
) (
    input logic                           clk,
    input logic                           rst,
    acondicionador_entradas_if.slave      bus
);

    typedef enum logic [1:0] {StIdle, StPend, StServ} req_state_e;

    localparam logic [CW-1:0] CntMax = CW'(DEB_TICKS - 1);

    // Input index: 0 sensor A, 1 sensor B, 2 button A, 3 button B.
    logic [3:0]         raw;
    logic [3:0]         sync1_q, sync2_q;
    logic [3:0]         stable_q, stable_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;

    // Street index: 0 A, 1 B.
    logic [1:0]         btn_d_q;
    logic [1:0]         press;
    logic [1:0]         rojo_s_q, rojo_d_q;
    logic [1:0]         rojo_rise, rojo_fall;
    req_state_e         state_q [2];
    req_state_e         state_d [2];
    logic [1:0]         rearm_q, rearm_d;

    logic [1:0]         sensor_q;
    logic [1:0]         paso_q, paso_d;

    assign raw = {bus.raw_paso_b, bus.raw_paso_a, bus.raw_sensor_b, bus.raw_sensor_a};

    // Debounce: a new level is accepted only after DEB_TICKS consecutive differing ticks.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (bus.tick) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press     = stable_q[3:2] & ~btn_d_q;
    // Edges are taken between the registered red light and its one-clk-delayed copy.
    assign rojo_rise = rojo_s_q & ~rojo_d_q;
    assign rojo_fall = ~rojo_s_q & rojo_d_q;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            state_d[s] = state_q[s];
            rearm_d[s] = rearm_q[s];
            unique case (state_q[s])
                StIdle: begin
                    if (press[s]) state_d[s] = StPend;
                end
                StPend: begin
                    if (rojo_rise[s]) state_d[s] = StServ;
                end
                StServ: begin
                    // A press arriving together with the end of red still counts as rearm.
                    if (rojo_fall[s]) begin
                        state_d[s] = (rearm_q[s] || press[s]) ? StPend : StIdle;
                        rearm_d[s] = 1'b0;
                    end else if (press[s]) begin
                        rearm_d[s] = 1'b1;
                    end
                end
                default: begin
                    state_d[s] = StIdle;
                    rearm_d[s] = 1'b0;
                end
            endcase
            paso_d[s] = (state_d[s] == StPend);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            btn_d_q  <= '0;
            rojo_s_q <= '0;
            rojo_d_q <= '0;
            rearm_q  <= '0;
            sensor_q <= '0;
            paso_q   <= '0;
            for (int s = 0; s < 2; s++) state_q[s] <= StIdle;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            btn_d_q  <= stable_q[3:2];
            rojo_s_q <= {bus.rojo_b, bus.rojo_a};
            rojo_d_q <= rojo_s_q;
            rearm_q  <= rearm_d;
            sensor_q <= stable_q[1:0];
            paso_q   <= paso_d;
            for (int s = 0; s < 2; s++) state_q[s] <= state_d[s];
        end
    end

    assign bus.sensor_a = sensor_q[0];
    assign bus.sensor_b = sensor_q[1];
    assign bus.paso_a   = paso_q[0];
    assign bus.paso_b   = paso_q[1];

endmodule
